hi_fsk_demod: RTL and testbench

- Consumes the per-edge subcarrier period values produced by the HF FSK reader stage. These are edge-to-edge counts in 13.56 MHz clocks: 32 for 423.75 kHz, 28 for 484.28 kHz, 0 for no signal.
- Groups consecutive periods into tone runs and turns runs into ISO15693 dual-subcarrier half-bits, then bits, then LSB-first bytes.
- Sits between the FSK period extractor and the SSP/ARM packing logic.

---
 rtl/hi_fsk_demod_pkg.sv | 34 +++
 rtl/fsk_run_classifier.sv | 106 ++++++++++
 rtl/hi_fsk_demod.sv | 173 +++++++++++++++++
 tb/tb_hi_fsk_demod.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hi_fsk_demod_pkg.sv
// Shared tone/state codes, pairing record and default thresholds for the
// HF FSK dual-subcarrier demodulator.
package hi_fsk_demod_pkg;

  typedef enum logic [1:0] {
    TONE_NONE = 2'd0,
    TONE_LO   = 2'd1,
    TONE_HI   = 2'd2
  } tone_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    tone_t pend;
    logic  vld;
    logic  bit_val;
    logic  err;
  } pair_t;

  localparam int DEF_LO_MIN     = 30;
  localparam int DEF_LO_MAX     = 34;
  localparam int DEF_HI_MIN     = 26;
  localparam int DEF_HI_MAX     = 29;
  localparam int DEF_LO_RUN_MIN = 7;
  localparam int DEF_LO_RUN_MAX = 9;
  localparam int DEF_HI_RUN_MIN = 8;
  localparam int DEF_HI_RUN_MAX = 10;
  localparam int DEF_TIMEOUT    = 80;

endpackage

// File: rtl/fsk_run_classifier.sv
// Classifies subcarrier periods into tones, tracks the current tone run and
// reports how many half-bits a closing run represents.
module fsk_run_classifier
  import hi_fsk_demod_pkg::*;
#(
  parameter int LO_MIN     = DEF_LO_MIN,
  parameter int LO_MAX     = DEF_LO_MAX,
  parameter int HI_MIN     = DEF_HI_MIN,
  parameter int HI_MAX     = DEF_HI_MAX,
  parameter int LO_RUN_MIN = DEF_LO_RUN_MIN,
  parameter int LO_RUN_MAX = DEF_LO_RUN_MAX,
  parameter int HI_RUN_MIN = DEF_HI_RUN_MIN,
  parameter int HI_RUN_MAX = DEF_HI_RUN_MAX
) (
  input  logic       ck_1356meg,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] period_in,
  input  logic       period_valid,
  input  logic       flush,
  output logic [1:0] half_cnt,
  output tone_t      half_tone,
  output logic       run_err,
  output logic       inv_err,
  output logic       zero_seen,
  output logic       tone_seen
);

  localparam logic [7:0] LO_MIN_C = 8'(LO_MIN);
  localparam logic [7:0] LO_MAX_C = 8'(LO_MAX);
  localparam logic [7:0] HI_MIN_C = 8'(HI_MIN);
  localparam logic [7:0] HI_MAX_C = 8'(HI_MAX);
  localparam logic [4:0] LO_R1_MIN = 5'(LO_RUN_MIN);
  localparam logic [4:0] LO_R1_MAX = 5'(LO_RUN_MAX);
  localparam logic [4:0] LO_R2_MIN = 5'(2 * LO_RUN_MIN);
  localparam logic [4:0] LO_R2_MAX = 5'(2 * LO_RUN_MAX);
  localparam logic [4:0] HI_R1_MIN = 5'(HI_RUN_MIN);
  localparam logic [4:0] HI_R1_MAX = 5'(HI_RUN_MAX);
  localparam logic [4:0] HI_R2_MIN = 5'(2 * HI_RUN_MIN);
  localparam logic [4:0] HI_R2_MAX = 5'(2 * HI_RUN_MAX);

  tone_t      run_tone_q;
  logic [4:0] run_len_q;
  tone_t      cls_p0;
  logic       is_zero_p0;
  logic       is_inv_p0;
  logic       closing_p0;

  // Stage p0: classify the incoming period (ignored during the flush cycle)
  always_comb begin
    cls_p0     = TONE_NONE;
    is_zero_p0 = 1'b0;
    is_inv_p0  = 1'b0;
    if (period_valid && !flush) begin
      if (period_in >= LO_MIN_C && period_in <= LO_MAX_C)      cls_p0 = TONE_LO;
      else if (period_in >= HI_MIN_C && period_in <= HI_MAX_C) cls_p0 = TONE_HI;
      else if (period_in == 8'd0)                              is_zero_p0 = 1'b1;
      else                                                     is_inv_p0 = 1'b1;
    end
  end

  // A run closes when the other tone starts or when the frame is flushed
  assign closing_p0 = flush ? (run_tone_q != TONE_NONE)
                            : (cls_p0 != TONE_NONE && run_tone_q != TONE_NONE &&
                               cls_p0 != run_tone_q);

  always_comb begin
    half_cnt = 2'd0;
    run_err  = 1'b0;
    if (closing_p0) begin
      if (run_tone_q == TONE_LO) begin
        if (run_len_q >= LO_R1_MIN && run_len_q <= LO_R1_MAX)      half_cnt = 2'd1;
        else if (run_len_q >= LO_R2_MIN && run_len_q <= LO_R2_MAX) half_cnt = 2'd2;
        else                                                       run_err = 1'b1;
      end else begin
        if (run_len_q >= HI_R1_MIN && run_len_q <= HI_R1_MAX)      half_cnt = 2'd1;
        else if (run_len_q >= HI_R2_MIN && run_len_q <= HI_R2_MAX) half_cnt = 2'd2;
        else                                                       run_err = 1'b1;
      end
    end
  end

  assign half_tone = run_tone_q;
  assign inv_err   = is_inv_p0;
  assign zero_seen = is_zero_p0;
  assign tone_seen = (cls_p0 != TONE_NONE);

  // Stage p1: run state register
  always_ff @(posedge ck_1356meg) begin
    if (!rst_n || !enable) begin
      run_tone_q <= TONE_NONE;
      run_len_q  <= 5'd0;
    end else if (flush || is_inv_p0) begin
      run_tone_q <= TONE_NONE;
      run_len_q  <= 5'd0;
    end else if (cls_p0 != TONE_NONE) begin
      if (cls_p0 == run_tone_q) begin
        if (run_len_q != 5'd31) run_len_q <= run_len_q + 5'd1;
      end else begin
        run_tone_q <= cls_p0;
        run_len_q  <= 5'd1;
      end
    end
  end

endmodule

// File: rtl/hi_fsk_demod.sv
// ISO15693 dual-subcarrier demodulator: pairs tone half-bits into bits,
// packs LSB-first bytes and frames the reply with a timeout/ZERO flush.
module hi_fsk_demod
  import hi_fsk_demod_pkg::*;
#(
  parameter int LO_MIN     = DEF_LO_MIN,
  parameter int LO_MAX     = DEF_LO_MAX,
  parameter int HI_MIN     = DEF_HI_MIN,
  parameter int HI_MAX     = DEF_HI_MAX,
  parameter int LO_RUN_MIN = DEF_LO_RUN_MIN,
  parameter int LO_RUN_MAX = DEF_LO_RUN_MAX,
  parameter int HI_RUN_MIN = DEF_HI_RUN_MIN,
  parameter int HI_RUN_MAX = DEF_HI_RUN_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic       ck_1356meg,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] period_in,
  input  logic       period_valid,
  output logic       bit_out,
  output logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       byte_partial,
  output logic       frame_active,
  output logic       frame_end,
  output logic       sym_err,
  output logic [7:0] err_count
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state_q, state_d;
  tone_t      pend_q;
  logic [7:0] idle_q;
  logic [3:0] bcnt_q, bcnt_d;
  logic [7:0] byte_q, byte_d;

  logic [1:0] half_cnt;
  tone_t      half_tone;
  logic       run_err, inv_err, zero_seen, tone_seen;
  logic       flush, timeout;

  pair_t      pr_p0;
  logic [7:0] byte_p0;
  logic       byte_vld_p0, partial_p0, fend_p0;

  function automatic pair_t pair_half(input pair_t s, input tone_t t);
    pair_t r;
    r = s;
    if (s.pend == TONE_NONE) begin
      r.pend = t;
    end else if (s.pend != t) begin
      r.vld     = 1'b1;
      r.bit_val = (s.pend == TONE_HI);
      r.pend    = TONE_NONE;
    end else begin
      // two equal halves cannot form a bit: keep the newer one to realign
      r.err  = 1'b1;
      r.pend = t;
    end
    return r;
  endfunction

  fsk_run_classifier #(
    .LO_MIN(LO_MIN), .LO_MAX(LO_MAX), .HI_MIN(HI_MIN), .HI_MAX(HI_MAX),
    .LO_RUN_MIN(LO_RUN_MIN), .LO_RUN_MAX(LO_RUN_MAX),
    .HI_RUN_MIN(HI_RUN_MIN), .HI_RUN_MAX(HI_RUN_MAX)
  ) u_cls (
    .ck_1356meg  (ck_1356meg),
    .rst_n       (rst_n),
    .enable      (enable),
    .period_in   (period_in),
    .period_valid(period_valid),
    .flush       (flush),
    .half_cnt    (half_cnt),
    .half_tone   (half_tone),
    .run_err     (run_err),
    .inv_err     (inv_err),
    .zero_seen   (zero_seen),
    .tone_seen   (tone_seen)
  );

  assign flush   = (state_q == FLUSH);
  assign timeout = (state_q == RUN) && !period_valid && (idle_q >= TIMEOUT_C);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tone_seen) state_d = RUN;
      RUN:     if (zero_seen || timeout) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: half-bit pairing, byte packing and flush bookkeeping
  always_comb begin
    pr_p0.pend    = pend_q;
    pr_p0.vld     = 1'b0;
    pr_p0.bit_val = 1'b0;
    pr_p0.err     = run_err | inv_err;
    if (run_err || inv_err) pr_p0.pend = TONE_NONE;
    if (half_cnt != 2'd0) pr_p0 = pair_half(pr_p0, half_tone);
    if (half_cnt == 2'd2) pr_p0 = pair_half(pr_p0, half_tone);

    byte_d      = (bcnt_q == 4'd0) ? 8'h00 : byte_q;
    bcnt_d      = bcnt_q;
    byte_p0     = 8'h00;
    byte_vld_p0 = 1'b0;
    partial_p0  = 1'b0;
    if (pr_p0.vld) begin
      byte_d[bcnt_q[2:0]] = pr_p0.bit_val;
      bcnt_d = bcnt_q + 4'd1;
      if (bcnt_d == 4'd8) begin
        byte_vld_p0 = 1'b1;
        byte_p0     = byte_d;
        bcnt_d      = 4'd0;
      end
    end

    fend_p0 = 1'b0;
    if (flush) begin
      if (bcnt_d != 4'd0) begin
        byte_vld_p0 = 1'b1;
        partial_p0  = 1'b1;
        byte_p0     = byte_d;
      end
      if (pr_p0.pend != TONE_NONE) pr_p0.err = 1'b1;
      pr_p0.pend = TONE_NONE;
      bcnt_d     = 4'd0;
      fend_p0    = frame_active || (half_cnt != 2'd0);
    end
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge ck_1356meg) begin
    if (!rst_n || !enable) begin
      state_q      <= IDLE;
      pend_q       <= TONE_NONE;
      idle_q       <= 8'd0;
      bcnt_q       <= 4'd0;
      byte_q       <= 8'h00;
      bit_out      <= 1'b0;
      bit_valid    <= 1'b0;
      byte_out     <= 8'h00;
      byte_valid   <= 1'b0;
      byte_partial <= 1'b0;
      frame_active <= 1'b0;
      frame_end    <= 1'b0;
      sym_err      <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pr_p0.pend;
      bcnt_q  <= bcnt_d;
      byte_q  <= byte_d;
      if (period_valid || state_q != RUN) idle_q <= 8'd0;
      else if (idle_q != 8'hFF)           idle_q <= idle_q + 8'd1;
      bit_out      <= pr_p0.bit_val;
      bit_valid    <= pr_p0.vld;
      byte_out     <= byte_p0;
      byte_valid   <= byte_vld_p0;
      byte_partial <= partial_p0;
      frame_end    <= fend_p0;
      frame_active <= flush ? 1'b0 : (frame_active | (half_cnt != 2'd0));
      sym_err      <= pr_p0.err;
      if (pr_p0.err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_hi_fsk_demod.sv
// Directed bench for hi_fsk_demod: nominal tone runs, merged runs, errors,
// timeout race and mid-frame reset.
module tb_hi_fsk_demod;

  logic       clk = 1'b0;
  logic       rst_n, enable, period_valid;
  logic [7:0] period_in;
  logic       bit_out, bit_valid, byte_valid, byte_partial;
  logic       frame_active, frame_end, sym_err;
  logic [7:0] byte_out, err_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic       bits_q[$];
  logic [7:0] bytes_q[$];
  logic       parts_q[$];
  int         errs = 0, fends = 0, byte_nobit = 0;
  logic [1:0] hq[$];

  hi_fsk_demod dut (
    .ck_1356meg  (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .period_in   (period_in),
    .period_valid(period_valid),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_partial(byte_partial),
    .frame_active(frame_active),
    .frame_end   (frame_end),
    .sym_err     (sym_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bit_valid) bits_q.push_back(bit_out);
    if (byte_valid) begin
      bytes_q.push_back(byte_out);
      parts_q.push_back(byte_partial);
      if (!byte_partial && !bit_valid) byte_nobit++;
    end
    if (sym_err) errs++;
    if (frame_end) fends++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_period(input logic [7:0] p);
    period_in    = p;
    period_valid = 1'b1;
    @(posedge clk);
    #1;
    period_valid = 1'b0;
    period_in    = 8'd0;
  endtask

  // tone 1 = low (period 32), tone 2 = high (period 28)
  task automatic send_run(input int tone, input int len);
    repeat (len) send_period(tone == 1 ? 8'd32 : 8'd28);
  endtask

  task automatic add_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      if (d[i]) begin hq.push_back(2'd2); hq.push_back(2'd1); end
      else      begin hq.push_back(2'd1); hq.push_back(2'd2); end
    end
  endtask

  // Merges adjacent equal halves into double runs; the last run stays open
  task automatic play();
    int i;
    int k;
    i = 0;
    while (i < hq.size()) begin
      k = 1;
      if (i + 1 < hq.size() && hq[i+1] == hq[i]) k = 2;
      send_run(int'(hq[i]), k * (hq[i] == 2'd1 ? 8 : 9));
      i += k;
    end
    hq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int b0;
    do_reset();
    n_checks++;
    if ({bit_out, bit_valid, byte_out, byte_valid, byte_partial, frame_active,
         frame_end, sym_err, err_count} !== 23'd0) begin
      $display("FAIL reset_outputs: got %h required 0", {bit_out, bit_valid, byte_out,
               byte_valid, byte_partial, frame_active, frame_end, sym_err, err_count});
      n_fail++;
    end
    b0 = bits_q.size();
    enable = 1'b0;
    send_run(1, 8); send_run(2, 9); send_period(8'd32);
    n_checks++;
    if (bits_q.size() != b0 || frame_active !== 1'b0) begin
      $display("FAIL enable_low: bits %0d frame_active %b required 0 0", bits_q.size() - b0, frame_active);
      n_fail++;
    end
    enable = 1'b1;
  endtask

  task automatic test_bit0();
    int b0, e0;
    do_reset();
    b0 = bits_q.size(); e0 = errs;
    send_run(1, 8); send_run(2, 9); send_period(8'd32);
    n_checks++;
    if (bit_valid !== 1'b1 || bit_out !== 1'b0) begin
      $display("FAIL bit0_strobe: valid %b bit %b required 1 0", bit_valid, bit_out);
      n_fail++;
    end
    n_checks++;
    if (frame_active !== 1'b1) begin
      $display("FAIL bit0_frame_active: got %b required 1", frame_active);
      n_fail++;
    end
    idle(1);
    n_checks++;
    if (bit_valid !== 1'b0 || bits_q.size() - b0 != 1 || errs != e0) begin
      $display("FAIL bit0_single: valid %b bits %0d errs %0d required 0 1 0",
               bit_valid, bits_q.size() - b0, errs - e0);
      n_fail++;
    end
  endtask

  task automatic test_byte_a5();
    int b0, y0, f0, e0;
    logic [7:0] v;
    do_reset();
    b0 = bits_q.size(); y0 = bytes_q.size(); f0 = fends; e0 = errs;
    add_bits(8'hA5, 8);
    play();
    n_checks++;
    if (frame_active !== 1'b1) begin
      $display("FAIL a5_frame_active: got %b required 1", frame_active);
      n_fail++;
    end
    idle(100);
    v = 8'h00;
    for (int i = 0; i < 8; i++) if (b0 + i < bits_q.size()) v[i] = bits_q[b0+i];
    n_checks++;
    if (bits_q.size() - b0 != 8 || v !== 8'hA5) begin
      $display("FAIL a5_bits: count %0d value %h required 8 a5", bits_q.size() - b0, v);
      n_fail++;
    end
    n_checks++;
    if (bytes_q.size() - y0 != 1 || bytes_q[y0] !== 8'hA5 || parts_q[y0] !== 1'b0) begin
      $display("FAIL a5_byte: count %0d byte %h partial %b required 1 a5 0",
               bytes_q.size() - y0, bytes_q[y0], parts_q[y0]);
      n_fail++;
    end
    n_checks++;
    if (fends - f0 != 1 || frame_active !== 1'b0 || errs != e0 || byte_nobit != 0) begin
      $display("FAIL a5_frame: frame_end %0d active %b errs %0d nobit %0d required 1 0 0 0",
               fends - f0, frame_active, errs - e0, byte_nobit);
      n_fail++;
    end
  endtask

  task automatic test_merged();
    int b0, y0, f0, e0;
    do_reset();
    b0 = bits_q.size(); y0 = bytes_q.size(); f0 = fends; e0 = errs;
    send_run(2, 9); send_run(1, 16); send_run(2, 9);
    idle(100);
    n_checks++;
    if (bits_q.size() - b0 != 2 || bits_q[b0] !== 1'b1 || bits_q[b0+1] !== 1'b0) begin
      $display("FAIL merged_bits: count %0d first %b second %b required 2 1 0",
               bits_q.size() - b0, bits_q[b0], bits_q[b0+1]);
      n_fail++;
    end
    n_checks++;
    if (bytes_q.size() - y0 != 1 || bytes_q[y0] !== 8'h01 || parts_q[y0] !== 1'b1) begin
      $display("FAIL merged_partial: count %0d byte %h partial %b required 1 01 1",
               bytes_q.size() - y0, bytes_q[y0], parts_q[y0]);
      n_fail++;
    end
    n_checks++;
    if (fends - f0 != 1 || errs != e0) begin
      $display("FAIL merged_frame: frame_end %0d errs %0d required 1 0", fends - f0, errs - e0);
      n_fail++;
    end
  endtask

  task automatic test_invalid();
    int b0;
    do_reset();
    send_run(1, 8); send_run(2, 4);
    send_period(8'd40);
    n_checks++;
    if (sym_err !== 1'b1 || err_count !== 8'd1) begin
      $display("FAIL invalid_err: sym_err %b err_count %0d required 1 1", sym_err, err_count);
      n_fail++;
    end
    b0 = bits_q.size();
    send_run(2, 9); send_run(1, 8); send_period(8'd28);
    n_checks++;
    if (bit_valid !== 1'b1 || bit_out !== 1'b1 || bits_q.size() != b0) begin
      $display("FAIL invalid_realign: valid %b bit %b earlier_bits %0d required 1 1 0",
               bit_valid, bit_out, bits_q.size() - b0);
      n_fail++;
    end
    n_checks++;
    if (err_count !== 8'd1) begin
      $display("FAIL invalid_count: got %0d required 1", err_count);
      n_fail++;
    end
  endtask

  task automatic test_bad_run();
    int f0;
    do_reset();
    f0 = fends;
    send_run(1, 12); send_period(8'd28);
    n_checks++;
    if (sym_err !== 1'b1 || bit_valid !== 1'b0) begin
      $display("FAIL badrun_err: sym_err %b bit_valid %b required 1 0", sym_err, bit_valid);
      n_fail++;
    end
    send_run(2, 8); send_period(8'd32);
    idle(80);
    send_period(8'd32);
    send_run(1, 6); send_period(8'd28);
    n_checks++;
    if (bit_valid !== 1'b1 || bit_out !== 1'b1 || fends != f0 || frame_active !== 1'b1) begin
      $display("FAIL timeout_race: valid %b bit %b frame_end %0d active %b required 1 1 0 1",
               bit_valid, bit_out, fends - f0, frame_active);
      n_fail++;
    end
    idle(100);
    n_checks++;
    if (fends - f0 != 1 || err_count !== 8'd2) begin
      $display("FAIL badrun_flush: frame_end %0d err_count %0d required 1 2", fends - f0, err_count);
      n_fail++;
    end
  endtask

  task automatic test_boundaries();
    int e0;
    do_reset();
    e0 = errs;
    for (int i = 0; i < 8; i++) send_period((i % 2) != 0 ? 8'd34 : 8'd30);
    for (int i = 0; i < 9; i++) send_period((i % 2) != 0 ? 8'd29 : 8'd26);
    send_period(8'd30);
    n_checks++;
    if (bit_valid !== 1'b1 || bit_out !== 1'b0 || errs != e0) begin
      $display("FAIL bounds_inrange: valid %b bit %b errs %0d required 1 0 0", bit_valid, bit_out, errs - e0);
      n_fail++;
    end
    send_period(8'd35);
    n_checks++;
    if (sym_err !== 1'b1) begin
      $display("FAIL bounds_35: sym_err %b required 1", sym_err);
      n_fail++;
    end
    send_period(8'd25);
    n_checks++;
    if (sym_err !== 1'b1 || err_count !== 8'd2) begin
      $display("FAIL bounds_25: sym_err %b err_count %0d required 1 2", sym_err, err_count);
      n_fail++;
    end
  endtask

  task automatic test_reset_midframe();
    int y0, f0, e0;
    do_reset();
    y0 = bytes_q.size();
    add_bits(8'h12, 8); add_bits(8'h34, 8); add_bits(8'h07, 3);
    play();
    n_checks++;
    if (bytes_q.size() - y0 != 2 || bytes_q[y0] !== 8'h12 || bytes_q[y0+1] !== 8'h34) begin
      $display("FAIL midframe_bytes: count %0d b0 %h b1 %h required 2 12 34",
               bytes_q.size() - y0, bytes_q[y0], bytes_q[y0+1]);
      n_fail++;
    end
    f0 = fends;
    rst_n = 1'b0;
    idle(1);
    n_checks++;
    if ({bit_out, bit_valid, byte_out, byte_valid, byte_partial, frame_active,
         frame_end, sym_err, err_count} !== 23'd0) begin
      $display("FAIL midframe_reset: got %h required 0", {bit_out, bit_valid, byte_out,
               byte_valid, byte_partial, frame_active, frame_end, sym_err, err_count});
      n_fail++;
    end
    idle(1);
    rst_n = 1'b1;
    idle(2);
    n_checks++;
    if (fends != f0) begin
      $display("FAIL midframe_no_end: frame_end %0d required 0", fends - f0);
      n_fail++;
    end
    y0 = bytes_q.size(); f0 = fends; e0 = errs;
    add_bits(8'hC3, 8);
    play();
    send_period(8'd0);
    idle(3);
    n_checks++;
    if (bytes_q.size() - y0 != 1 || bytes_q[y0] !== 8'hC3 || parts_q[y0] !== 1'b0 ||
        fends - f0 != 1 || errs != e0) begin
      $display("FAIL midframe_next: count %0d byte %h partial %b frame_end %0d errs %0d required 1 c3 0 1 0",
               bytes_q.size() - y0, bytes_q[y0], parts_q[y0], fends - f0, errs - e0);
      n_fail++;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b1;
    period_valid = 1'b0;
    period_in    = 8'd0;
    test_reset();
    test_bit0();
    test_byte_a5();
    test_merged();
    test_invalid();
    test_bad_run();
    test_boundaries();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
